// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Decides the write enables, flushes and bubbles for PC, IF/ID, ID/EX and
// EX/MEM. A memory stall outranks a taken branch, and a taken branch
// outranks a load-use hazard.
// Optional feature: define STALL_CNT_EN to build the saturating stall and
// flush performance counters. Without it both count ports are tied to 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal issue; branch and load-use hazards are both honoured
// LU_MASK | one cycle after a load-use bubble; repeat hazard is ignored
// FLUSH   | trailing IF/ID flush cycles of a taken branch (fcnt left)
module pipeline_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU_MASK = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // The branch cycle is itself the first flush, so FLUSH covers the rest.
  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;

  // State register and flush down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next-state and Mealy outputs; reset forces a squashing output pattern.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b1;
    if (!rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      exmem_we    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      exmem_we = 1'b0;
    end else begin
      case (state_q)
        RUN, LU_MASK: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              fcnt_d  = FCNT_INIT;
            end else begin
              state_d = RUN;
            end
          end else if (hazard && (state_q == RUN)) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            state_d     = LU_MASK;
          end else begin
            state_d = RUN;
          end
        end
        FLUSH: begin
          // Hazard and branch here come from wrong-path instructions.
          ifid_flush = 1'b1;
          fcnt_d     = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) begin
            state_d = RUN;
            fcnt_d  = 3'd0;
          end
        end
        default: begin
          state_d = RUN;
          fcnt_d  = 3'd0;
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic             stall_evt;
  logic             flush_evt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  assign stall_evt = rst && !mem_busy && !branch_taken && hazard && (state_q == RUN);
  assign flush_evt = rst && !mem_busy && ifid_flush;

  // Saturating performance counters; they hold during a memory freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) stall_q <= stall_q + CNT_ONE;
      if (flush_evt && (flush_q != '1)) flush_q <= flush_q + CNT_ONE;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl: two instances (3-cycle flush with
// 16-bit counters, 1-cycle flush with 4-bit counters) share the inputs and
// are checked each cycle against a slot-level reference model, plus a
// table of hand-derived vectors for the 3-cycle instance.
module tb_pipeline_stall_ctrl;

`ifdef STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hazard = 1'b0;
  logic branch_taken = 1'b0;
  logic mem_busy = 1'b0;

  logic a_pc, a_ifid, a_fl, a_bub, a_ex;
  logic [15:0] a_stall, a_flush;
  logic b_pc, b_ifid, b_fl, b_bub, b_ex;
  logic [3:0] b_stall, b_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u_fc3 (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_we(a_pc), .ifid_we(a_ifid), .ifid_flush(a_fl),
    .idex_bubble(a_bub), .exmem_we(a_ex), .stall_cycles(a_stall),
    .flush_cycles(a_flush));

  pipeline_stall_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u_fc1 (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_we(b_pc), .ifid_we(b_ifid), .ifid_flush(b_fl),
    .idex_bubble(b_bub), .exmem_we(b_ex), .stall_cycles(b_stall),
    .flush_cycles(b_flush));

  // Reference model: slots of forced flush still owed, whether the previous
  // slot already paid the bubble for this load, and event tallies.
  typedef struct {
    int flush_left;
    bit masked;
    int stalls;
    int flushes;
  } mst_t;

  mst_t m3, m1;

  // {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we}
  localparam logic [4:0] O_RST = 5'b00110;
  localparam logic [4:0] O_RUN = 5'b11001;
  localparam logic [4:0] O_FRZ = 5'b00000;
  localparam logic [4:0] O_BR  = 5'b11111;
  localparam logic [4:0] O_FL  = 5'b11101;
  localparam logic [4:0] O_LU  = 5'b00011;

  function automatic int sat(input int v, input int cap);
    return (v > cap) ? cap : v;
  endfunction

  function automatic void mstep(input mst_t s, input int fc, input int cap,
                                input bit r, input bit h, input bit b, input bit m,
                                output logic [4:0] o, output mst_t n);
    n = s;
    o = O_RUN;
    if (!r) begin
      o = O_RST;
      n.flush_left = 0; n.masked = 1'b0; n.stalls = 0; n.flushes = 0;
    end else if (m) begin
      o = O_FRZ;
    end else if (s.flush_left > 0) begin
      o = O_FL;
      n.flush_left = s.flush_left - 1;
      n.flushes = sat(s.flushes + 1, cap);
    end else if (b) begin
      o = O_BR;
      n.flush_left = fc - 1;
      n.masked = 1'b0;
      n.flushes = sat(s.flushes + 1, cap);
    end else if (h && !s.masked) begin
      o = O_LU;
      n.masked = 1'b1;
      n.stalls = sat(s.stalls + 1, cap);
    end else begin
      n.masked = 1'b0;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [4:0] last_o3;

  // One clock: drive at negedge, compare 1 time unit later, advance model at posedge.
  task automatic cycle(input bit r, input bit h, input bit b, input bit m, input string tag);
    logic [4:0] o3, o1;
    mst_t n3, n1;
    rst = r; hazard = h; branch_taken = b; mem_busy = m;
    if (!r) begin
      m3 = '{0, 1'b0, 0, 0};
      m1 = '{0, 1'b0, 0, 0};
    end
    #1;
    mstep(m3, 3, 65535, r, h, b, m, o3, n3);
    mstep(m1, 1, 15, r, h, b, m, o1, n1);
    last_o3 = {a_pc, a_ifid, a_fl, a_bub, a_ex};
    check({tag, " fc3 outs"}, int'(last_o3), int'(o3));
    check({tag, " fc1 outs"}, int'({b_pc, b_ifid, b_fl, b_bub, b_ex}), int'(o1));
    check({tag, " fc3 stall_cycles"}, int'(a_stall), CNT_EN ? m3.stalls : 0);
    check({tag, " fc3 flush_cycles"}, int'(a_flush), CNT_EN ? m3.flushes : 0);
    check({tag, " fc1 stall_cycles"}, int'(b_stall), CNT_EN ? m1.stalls : 0);
    check({tag, " fc1 flush_cycles"}, int'(b_flush), CNT_EN ? m1.flushes : 0);
    @(posedge clk);
    m3 = n3;
    m1 = n1;
    @(negedge clk);
  endtask

  typedef struct {
    bit r, h, b, m;
    logic [4:0] exp3;
  } vec_t;

  vec_t vecs[$];

  initial begin
    m3 = '{0, 1'b0, 0, 0};
    m1 = '{0, 1'b0, 0, 0};
    // Hand-derived expectations for the FLUSH_CYCLES=3 instance.
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, O_RST});  // in reset
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, O_RUN});  // first cycle after release
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, O_LU});   // load-use bubble
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, O_RUN});  // repeat hazard masked
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, O_RUN});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, O_BR});   // branch: flush 1 + bubble
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, O_FL});   // flush 2, wrong-path ignored
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, O_FL});   // flush 3
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, O_RUN});  // back in RUN
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, O_BR});   // branch beats hazard
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, O_FRZ});  // freeze x4 in 2nd flush slot
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, O_FRZ});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, O_FRZ});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, O_FRZ});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, O_FL});   // remaining flushes
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, O_FL});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, O_RUN});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, O_BR});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, O_FL});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, O_RST});  // reset mid-FLUSH
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, O_RUN});  // no residual flush
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, O_FRZ});  // hazard under freeze waits
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, O_LU});   // re-evaluated after freeze
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, O_RST});  // reset mid-LU_MASK
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, O_LU});   // hazard honoured again

    @(negedge clk);
    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].h, vecs[i].b, vecs[i].m, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table", i), int'(last_o3), int'(vecs[i].exp3));
    end

    // Load-use pulse of two cycles costs exactly one stall.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "lu rst");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "lu idle");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, "lu c1");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, "lu c2");
    check("lu stall count", int'(a_stall), CNT_EN ? 1 : 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, "hz+br");
    check("hz+br stall unchanged", int'(a_stall), CNT_EN ? 1 : 0);
    check("hz+br fc1 flush count", int'(b_flush), CNT_EN ? 1 : 0);

    // 20 separate load-use events: 4-bit counter saturates at 15.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "sat rst");
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, "sat hz");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, "sat idle");
    end
    check("sat fc1 stall_cycles", int'(b_stall), CNT_EN ? 15 : 0);
    check("sat fc3 stall_cycles", int'(a_stall), CNT_EN ? 20 : 0);

    // 22 branches: 4-bit flush counter saturates too.
    for (int i = 0; i < 22; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, "sat br");
    check("sat fc1 flush_cycles", int'(b_flush), CNT_EN ? 15 : 0);

    // Randomized traffic against the model.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "rnd rst");
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
